factory_test_checker: RTL and testbench

- Bench-side and bring-up-side counterpart of the factory test project: drives the project's dedicated inputs and checks its dedicated outputs.
- Two modes:
  - Echo: the project must return each driven byte after a fixed pipeline latency.
  - Counter: the project's output must increment by 1 every clock.
- Reports pass/fail, saturating error count and first-failure capture. Used in the cocotb bench and on the demo-board FPGA harness.

---
 rtl/factory_test_checker.sv | 112 +++++++++++
 tb/tb_factory_test_checker.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/factory_test_checker.sv
// factory_test_checker: drives the factory test project's inputs and checks its echo or counter outputs
module factory_test_checker #(
    parameter int LATENCY = 1,
    parameter int VECTORS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    output logic [7:0] ui_drv,
    input  logic [7:0] uo_obs,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [7:0] first_err_idx,
    output logic [7:0] first_err_data
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state;
    logic mode_q;
    logic [8:0] idx;
    logic [7:0] ref_q;
    logic [7:0] dl_data [LATENCY];
    logic [LATENCY-1:0] dl_valid;
    logic echo_err, cnt_err, mismatch, last_vec, last_drain;
    logic [7:0] err_idx, err_next;
    // Compare the observed byte against the expectation for this cycle and form the next error count
    always_comb begin
        echo_err = (state == RUN || state == DRAIN) && !mode_q && dl_valid[LATENCY-1] && uo_obs != dl_data[LATENCY-1];
        cnt_err = state == RUN && mode_q && idx != 9'd0 && uo_obs != ref_q + 8'd1;
        mismatch = echo_err || cnt_err;
        err_idx = mode_q ? idx[7:0] : dl_data[LATENCY-1];
        err_next = (mismatch && err_count != 8'hff) ? err_count + 8'd1 : err_count;
        last_vec = idx == 9'(VECTORS - 1);
        last_drain = idx == 9'(LATENCY - 1);
    end
    // Expected echo values travel alongside the project pipeline so each arrives with its response
    always_ff @(posedge clk) begin
        if (rst) begin
            dl_valid <= '0;
            for (int k = 0; k < LATENCY; k++) dl_data[k] <= 8'd0;
        end else begin
            dl_valid[0] <= state == RUN && !mode_q;
            dl_data[0] <= idx[7:0];
            for (int k = 1; k < LATENCY; k++) begin
                dl_valid[k] <= dl_valid[k-1];
                dl_data[k] <= dl_data[k-1];
            end
        end
    end
    // Run sequencing and result capture; the start branch overrides the error updates
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mode_q <= 1'b0;
            idx <= 9'd0;
            ref_q <= 8'd0;
            ui_drv <= 8'd0;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            err_count <= 8'd0;
            first_err_idx <= 8'd0;
            first_err_data <= 8'd0;
        end else begin
            err_count <= err_next;
            if (mismatch && err_count == 8'd0) begin
                first_err_idx <= err_idx;
                first_err_data <= uo_obs;
            end
            case (state)
                IDLE, DONE: if (start) begin
                    state <= RUN;
                    busy <= 1'b1;
                    done <= 1'b0;
                    pass <= 1'b0;
                    err_count <= 8'd0;
                    first_err_idx <= 8'd0;
                    first_err_data <= 8'd0;
                    mode_q <= mode;
                    idx <= 9'd0;
                    ui_drv <= 8'd0;
                end
                RUN: begin
                    ref_q <= uo_obs;
                    if (last_vec) begin
                        ui_drv <= 8'd0;
                        idx <= 9'd0;
                        state <= mode_q ? DONE : DRAIN;
                        busy <= !mode_q;
                        done <= mode_q;
                        pass <= mode_q && err_next == 8'd0;
                    end else begin
                        idx <= idx + 9'd1;
                        ui_drv <= mode_q ? 8'd0 : idx[7:0] + 8'd1;
                    end
                end
                DRAIN: begin
                    if (last_drain) begin
                        state <= DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= err_next == 8'd0;
                    end else begin
                        idx <= idx + 9'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_factory_test_checker.sv
// tb_factory_test_checker: table-driven and randomized checks of factory_test_checker against a spec-level model
module tb_factory_test_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;
    logic start_s [2];
    logic mode_s [2];
    logic echo_en [2];
    logic [7:0] drv_uo [2];
    logic [7:0] and_m [2];
    logic [7:0] xor_m [2];
    logic [7:0] ui0, ui1, uo0, uo1, err0, err1, fidx0, fidx1, fdat0, fdat1;
    logic busy0, busy1, done0, done1, pass0, pass1;
    logic [7:0] p0;
    logic [7:0] p1 [3];
    int checks = 0;
    int failures = 0;
    logic [7:0] obs [0:400];
    logic [7:0] uid [0:400];
    logic bsy [0:400];
    int done_cyc;

    typedef struct {
        int n; bit md; int kind; logic [7:0] base; int skip; logic [7:0] am; logic [7:0] xm; int pulse;
        int e_err; int e_idx; int e_data; bit e_pass;
    } vec_t;

    factory_test_checker #(.LATENCY(1), .VECTORS(16)) u0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .mode(mode_s[0]), .ui_drv(ui0), .uo_obs(uo0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_err_idx(fidx0), .first_err_data(fdat0));
    factory_test_checker #(.LATENCY(3), .VECTORS(256)) u1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .mode(mode_s[1]), .ui_drv(ui1), .uo_obs(uo1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_err_idx(fidx1), .first_err_data(fdat1));

    // Project models: echo pipelines of the checker's latency, or a bench-driven byte
    always_ff @(posedge clk) begin
        p0 <= ui0;
        p1[0] <= ui1;
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end
    assign uo0 = echo_en[0] ? ((p0 & and_m[0]) ^ xor_m[0]) : drv_uo[0];
    assign uo1 = echo_en[1] ? ((p1[2] & and_m[1]) ^ xor_m[1]) : drv_uo[1];

    function automatic int vof(int n); return n == 0 ? 16 : 256; endfunction
    function automatic int lof(int n); return n == 0 ? 1 : 3; endfunction
    function automatic logic g_busy(int n); return n == 0 ? busy0 : busy1; endfunction
    function automatic logic g_done(int n); return n == 0 ? done0 : done1; endfunction
    function automatic logic g_pass(int n); return n == 0 ? pass0 : pass1; endfunction
    function automatic logic [7:0] g_ui(int n); return n == 0 ? ui0 : ui1; endfunction
    function automatic logic [7:0] g_uo(int n); return n == 0 ? uo0 : uo1; endfunction
    function automatic logic [7:0] g_err(int n); return n == 0 ? err0 : err1; endfunction
    function automatic logic [7:0] g_fidx(int n); return n == 0 ? fidx0 : fidx1; endfunction
    function automatic logic [7:0] g_fdat(int n); return n == 0 ? fdat0 : fdat1; endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // One run: start in cycle 0, then per cycle drive the project and log what the checker sees and drives
    task automatic run(input int n, input bit md, input int kind, input logic [7:0] base, input int skip,
                       input logic [7:0] am, input logic [7:0] xm, input bit noise, input int pulse);
        echo_en[n] = kind == 0;
        and_m[n] = am;
        xor_m[n] = xm;
        drv_uo[n] = base;
        @(negedge clk);
        start_s[n] = 1'b1;
        mode_s[n] = md;
        done_cyc = -1;
        for (int c = 1; c <= 300 && done_cyc < 0; c++) begin
            @(negedge clk);
            start_s[n] = c == pulse;
            mode_s[n] = ~md;
            if (kind == 1) drv_uo[n] = base + 8'(c - 1) + 8'(c - 1 >= skip);
            if (kind == 0) xor_m[n] = xm;
            if (noise && $urandom_range(4) == 0) begin
                if (kind == 0) xor_m[n] = 8'($urandom);
                else drv_uo[n] = 8'($urandom);
            end
            #1;
            obs[c] = g_uo(n);
            uid[c] = g_ui(n);
            bsy[c] = g_busy(n);
            if (g_done(n)) done_cyc = c;
        end
        start_s[n] = 1'b0;
        mode_s[n] = 1'b0;
    endtask

    // Reference: apply the echo/counter rules to the logged observations by absolute cycle number
    task automatic ref_calc(input int n, input bit md, output int e_err, output int e_idx, output int e_data, output bit e_pass);
        int errs = 0;
        int v = vof(n);
        int l = lof(n);
        logic [7:0] want;
        e_idx = 0;
        e_data = 0;
        for (int i = md ? 1 : 0; i < v; i++) begin
            want = md ? obs[i] + 8'd1 : 8'(i);
            if ((md ? obs[1 + i] : obs[1 + i + l]) !== want) begin
                if (errs == 0) begin
                    e_idx = i;
                    e_data = int'(md ? obs[1 + i] : obs[1 + i + l]);
                end
                errs++;
            end
        end
        e_err = errs > 255 ? 255 : errs;
        e_pass = errs == 0;
    endtask

    task automatic check(input int n, input bit md, input string lbl, input int e_err, input int e_idx, input int e_data, input bit e_pass);
        int v = vof(n);
        int e_done = md ? v + 1 : v + lof(n) + 1;
        logic bok = 1'b1;
        logic uok = 1'b1;
        chk({lbl, " done_cycle"}, done_cyc, e_done);
        for (int c = 1; c <= e_done; c++) begin
            if (bsy[c] !== (c < e_done)) bok = 1'b0;
            if (uid[c] !== ((!md && c <= v) ? 8'(c - 1) : 8'h00)) uok = 1'b0;
        end
        chk({lbl, " busy_window"}, bok, 1);
        chk({lbl, " ui_drv_seq"}, uok, 1);
        chk({lbl, " err_count"}, g_err(n), e_err);
        chk({lbl, " first_err_idx"}, g_fidx(n), e_idx);
        chk({lbl, " first_err_data"}, g_fdat(n), e_data);
        chk({lbl, " pass"}, g_pass(n), e_pass);
    endtask

    initial begin
        vec_t tbl [9];
        int e_err, e_idx, e_data;
        bit e_pass, saw_done;
        tbl[0] = '{0, 1'b0, 0, 8'h00, 999, 8'hff, 8'h00, 0, 0, 0, 0, 1'b1};
        tbl[1] = '{0, 1'b0, 0, 8'h00, 999, 8'hf7, 8'h00, 0, 8, 8, 0, 1'b0};
        tbl[2] = '{0, 1'b1, 1, 8'h7e, 999, 8'hff, 8'h00, 0, 0, 0, 0, 1'b1};
        tbl[3] = '{0, 1'b1, 1, 8'h7e, 5, 8'hff, 8'h00, 0, 1, 5, 8'h84, 1'b0};
        tbl[4] = '{1, 1'b1, 2, 8'h33, 999, 8'hff, 8'h00, 0, 255, 1, 8'h33, 1'b0};
        tbl[5] = '{1, 1'b0, 0, 8'h00, 999, 8'hff, 8'h01, 0, 255, 0, 8'h01, 1'b0};
        tbl[6] = '{0, 1'b0, 0, 8'h00, 999, 8'hff, 8'h00, 4, 0, 0, 0, 1'b1};
        tbl[7] = '{0, 1'b1, 1, 8'hf8, 999, 8'hff, 8'h00, 3, 0, 0, 0, 1'b1};
        tbl[8] = '{1, 1'b0, 0, 8'h00, 999, 8'hff, 8'h00, 0, 0, 0, 0, 1'b1};
        for (int n = 0; n < 2; n++) begin
            start_s[n] = 1'b0;
            mode_s[n] = 1'b0;
            echo_en[n] = 1'b1;
            drv_uo[n] = 8'h00;
            and_m[n] = 8'hff;
            xor_m[n] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int n = 0; n < 2; n++) begin
            chk("reset busy", g_busy(n), 0);
            chk("reset done", g_done(n), 0);
            chk("reset pass", g_pass(n), 0);
            chk("reset ui_drv", g_ui(n), 0);
            chk("reset err_count", g_err(n), 0);
            chk("reset first_err", {g_fidx(n), g_fdat(n)}, 0);
        end
        rst = 1'b0;
        for (int t = 0; t < 9; t++) begin
            run(tbl[t].n, tbl[t].md, tbl[t].kind, tbl[t].base, tbl[t].skip, tbl[t].am, tbl[t].xm, 1'b0, tbl[t].pulse);
            check(tbl[t].n, tbl[t].md, $sformatf("vec%0d", t), tbl[t].e_err, tbl[t].e_idx, tbl[t].e_data, tbl[t].e_pass);
        end
        // Reset in the middle of a failing echo run discards it entirely
        echo_en[0] = 1'b1;
        and_m[0] = 8'h00;
        xor_m[0] = 8'h00;
        @(negedge clk);
        start_s[0] = 1'b1;
        mode_s[0] = 1'b0;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrun err_before_rst", err0, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun busy", busy0, 0);
        chk("midrun done", done0, 0);
        chk("midrun ui_drv", ui0, 0);
        chk("midrun err_count", err0, 0);
        saw_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done0 || busy0) saw_done = 1'b1;
        end
        chk("midrun no_partial_done", saw_done, 0);
        run(0, 1'b0, 0, 8'h00, 999, 8'hff, 8'h00, 1'b0, 0);
        check(0, 1'b0, "after_rst", 0, 0, 0, 1'b1);
        // Randomized runs checked against the reference model
        for (int r = 0; r < 8; r++) begin
            int n = r % 2;
            bit md = 1'($urandom);
            run(n, md, md ? 1 : 0, 8'($urandom), int'($urandom_range(vof(n), 1)),
                ($urandom_range(2) == 0) ? 8'($urandom) : 8'hff, 8'h00, 1'b1, int'($urandom_range(12, 2)));
            ref_calc(n, md, e_err, e_idx, e_data, e_pass);
            check(n, md, $sformatf("rand%0d", r), e_err, e_idx, e_data, e_pass);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
